// File: rtl/xadc_drp_sequencer_pkg.sv
// Shared constants, state encoding and slot-address lookup for the XADC DRP sequencer.
package xadc_pkg;

    localparam logic [6:0] ADDR_VAUX1 = 7'h11;
    localparam logic [6:0] ADDR_VAUX0 = 7'h10;
    localparam logic [6:0] ADDR_VAUX8 = 7'h18;
    localparam logic [6:0] ADDR_VAUX9 = 7'h19;

    // Slot 0 sits in the low bits, so the round-robin starts at VAUX1.
    localparam logic [27:0] DEFAULT_CH_ADDRS = {ADDR_VAUX9, ADDR_VAUX8, ADDR_VAUX0, ADDR_VAUX1};

    localparam int SAMPLE_W  = 12;
    localparam int NUM_SLOTS = 4;
    localparam int TMR_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EOC  = 2'd1,
        ST_WAIT_DRDY = 2'd2
    } seq_state_t;

    function automatic logic [6:0] slot_addr(input logic [27:0] addrs, input logic [1:0] idx);
        logic [6:0] a;
        case (idx)
            2'd0:    a = addrs[6:0];
            2'd1:    a = addrs[13:7];
            2'd2:    a = addrs[20:14];
            default: a = addrs[27:21];
        endcase
        return a;
    endfunction

endpackage

// File: rtl/xadc_drp_sequencer_if.sv
// DRP port bundle between the sequencer (master) and the XADC wizard (slave).
interface xadc_drp_if;
    logic [6:0]  daddr;
    logic        den;
    logic        dwe;
    logic        drdy;
    logic [15:0] do_in;

    modport master (output daddr, output den, output dwe, input drdy, input do_in);
    modport slave  (input daddr, input den, input dwe, output drdy, output do_in);
endinterface

// File: rtl/xadc_drp_sequencer_drp_timeout_counter.sv
// Loadable down-counter bounding the wait for DRDY; expired while the count sits at zero.
module drp_timeout_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk_sys,
    input  logic             rst_b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count_en,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count_en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Round-robin DRP reader for the four JXADC aux channels, one read per end-of-conversion.
//
// state        | meaning
// ST_IDLE      | sequencing disabled, no DRP traffic
// ST_WAIT_EOC  | armed, waiting for the next conversion to finish
// ST_WAIT_DRDY | read issued, waiting for DRDY or the timeout
module xadc_drp_sequencer
    import xadc_pkg::*;
#(
    parameter logic [27:0] CH_ADDRS       = DEFAULT_CH_ADDRS,
    parameter int          TIMEOUT_CYCLES = 1023
) (
    input  logic                CLK100MHZ,
    input  logic                RSTN,
    input  logic                run,
    input  logic                eoc,
    xadc_drp_if.master          drp,
    output logic [SAMPLE_W-1:0] ch_data0,
    output logic [SAMPLE_W-1:0] ch_data1,
    output logic [SAMPLE_W-1:0] ch_data2,
    output logic [SAMPLE_W-1:0] ch_data3,
    output logic [3:0]          ch_valid,
    output logic                sample_stb,
    output logic [1:0]          sample_ch,
    output logic                timeout_err
);

    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);

    seq_state_t          state, state_nxt;
    logic [1:0]          idx, idx_nxt;
    logic                den_q, den_nxt;
    logic [6:0]          daddr_q;
    logic                capture, tmo_hit;
    logic                tmr_load, tmr_expired;
    logic [SAMPLE_W-1:0] data_q [NUM_SLOTS];
    logic                unused_do_lsb;

    drp_timeout_counter #(
        .WIDTH (TMR_W)
    ) u_tmr (
        .clk_sys  (CLK100MHZ),
        .rst_b    (RSTN),
        .load     (tmr_load),
        .load_val (TMR_LOAD),
        .count_en (state == ST_WAIT_DRDY),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        den_nxt   = 1'b0;
        capture   = 1'b0;
        tmo_hit   = 1'b0;
        tmr_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_WAIT_EOC;
            end
            ST_WAIT_EOC: begin
                if (!run) begin
                    state_nxt = ST_IDLE;
                end else if (eoc) begin
                    den_nxt   = 1'b1;
                    tmr_load  = 1'b1;
                    state_nxt = ST_WAIT_DRDY;
                end
            end
            ST_WAIT_DRDY: begin
                // DRDY on the expiry cycle still counts as a good read.
                if (drdy_in()) begin
                    capture = 1'b1;
                end else if (tmr_expired) begin
                    tmo_hit = 1'b1;
                end
                if (capture || tmo_hit) begin
                    idx_nxt   = idx + 2'd1;
                    state_nxt = run ? ST_WAIT_EOC : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    function automatic logic drdy_in();
        return drp.drdy;
    endfunction

    always_ff @(posedge CLK100MHZ or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge RSTN) begin
        if (!RSTN) begin
            idx         <= 2'd0;
            daddr_q     <= slot_addr(CH_ADDRS, 2'd0);
            den_q       <= 1'b0;
            sample_stb  <= 1'b0;
            sample_ch   <= 2'd0;
            ch_valid    <= 4'b0000;
            timeout_err <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) data_q[i] <= '0;
        end else begin
            idx        <= idx_nxt;
            daddr_q    <= slot_addr(CH_ADDRS, idx_nxt);
            den_q      <= den_nxt;
            sample_stb <= capture;
            if (capture) begin
                data_q[idx]   <= drp.do_in[15:4];
                ch_valid[idx] <= 1'b1;
                sample_ch     <= idx;
            end
            if (tmo_hit) timeout_err <= 1'b1;
        end
    end

    assign drp.daddr = daddr_q;
    assign drp.den   = den_q;
    assign drp.dwe   = 1'b0;

    assign ch_data0 = data_q[0];
    assign ch_data1 = data_q[1];
    assign ch_data2 = data_q[2];
    assign ch_data3 = data_q[3];

    assign unused_do_lsb = ^drp.do_in[3:0];

endmodule
